gpio_ctrl: RTL
==============

# gpio_ctrl

Register-mapped controller for the 16-pin GPIO bank. It owns the per-pin output-data and direction vectors that drive `gpio_npins`. It brings the pin readback back into the clock domain through a two-flop synchronizer and detects rising edges into a maskable interrupt. Host access uses a single-outstanding req/ack handshake, so the bank can be configured from any simple bus bridge.

## Interface
Parameters:
- `NPINS`, default 16: number of GPIO pins; the width of every pin vector.
- `AW`, default 3: register address width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  host access request.
- `we`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  AW  register address.
- `wdata`  in  NPINS  write data.
- `ack`  out  1  one-cycle access-complete pulse.
- `rdata`  out  NPINS  read data; valid while `ack`=1, holds its value otherwise.
- `data_out`  out  NPINS  drives `gpio_npins.data_in`.
- `dir_out`  out  NPINS  drives `gpio_npins.dir_in`; 1 = output.
- `pins_in`  in  NPINS  from `gpio_npins.gpio_pins_out`; asynchronous to `clk`.
- `irq`  out  1  level interrupt, equal to |(IRQ_STAT & IRQ_EN).

## Operation
Register map:
- 0 DATA: RW.
- 1 DIR: RW.
- 2 INPUT: RO; synchronized `pins_in`.
- 3 IRQ_EN: RW.
- 4 IRQ_STAT: read, or write-1-to-clear.
- 5 SET: WO; DATA |= wdata.
- 6 CLR: WO; DATA &= ~wdata.
- 7: reserved.

Access rules:
- Reads of write-only or reserved addresses return 0.
- Writes to RO or reserved addresses are ignored.
- Every access is acked, including those to reserved addresses.

Access FSM, states IDLE and ACK:
- IDLE: if `req`=1, perform the write or capture `rdata`, then go to ACK.
- ACK: `ack`=1 for exactly one cycle, then return to IDLE.
- The host must hold `req`, `we`, `addr` and `wdata` until it sees `ack`.
- The host must deassert `req` in the ack cycle. A `req` still high in the following IDLE cycle is a new access.

Input path:
- `pins_in` passes through two flops (sync1, sync2) to produce INPUT.
- A third flop holds the previous sample (prev).
- rise = sync2 & ~prev.

Interrupt status:
- IRQ_STAT bit i sets on rise[i], regardless of IRQ_EN.
- If a W1C of bit i and rise[i] occur in the same cycle, set wins and the bit stays 1.
- IRQ_EN masks only `irq`, not the status bits.

Priming after reset:
- A 2-bit prime counter suppresses rise for the first 3 cycles after reset deasserts.
- This prevents pins that are high at reset from producing false edges.

Reset values:
- 0: DATA, DIR (all pins inputs), IRQ_EN, IRQ_STAT, sync1, sync2, prev, the prime counter, `ack`, `rdata`, `irq`.
- FSM state: IDLE.
- Reset asserted mid-access aborts the access; no write is committed and no `ack` is issued.

Arithmetic: all register operations are bitwise on NPINS bits; no carries.

## Timing
- `req` sampled high at edge N produces `ack` high between edges N+1 and N+2 (1-cycle latency).
- Minimum access period is 2 cycles.
- Writes take effect at edge N+1: `data_out`, `dir_out` and IRQ_EN are registered outputs updated at that edge.
- SET and CLR also update at edge N+1. Only one of them can occur per access, so they never collide.
- Reads return the register value as of edge N, held on `rdata` at edge N+1.
- Input latency: a `pins_in` change settled before edge K appears in sync1 at K and in INPUT (sync2) at K+1.
- That change sets IRQ_STAT at K+2, and `irq` follows combinationally from the registered status.
- W1C at edge N+1 drops `irq` in the same cycle, unless another enabled status bit remains set or a new rise occurs.

## Structure
- Package `gpio_ctrl_pkg`:
  - register address constants (ADDR_DATA … ADDR_CLR);
  - FSM state enum {IDLE, ACK};
  - the prime count constant (3).
- Sub-module `gpio_sync_edge`:
  - NPINS-wide sync1/sync2/prev pipeline plus the prime counter;
  - outputs the synchronized value and the rise vector;
  - instantiated once.
- Top level: access FSM, register file, IRQ_STAT set/clear logic, `irq` reduction.

## Test plan
- Reset with `pins_in`=16'hFFFF, release reset, wait 10 cycles -> IRQ_STAT reads 0, `irq`=0, `data_out`=`dir_out`=0.
- Write DATA=16'hA5A5, write SET=16'h000F, write CLR=16'h0100 -> `data_out`=16'hA4AF. Each `ack` arrives exactly 1 cycle after `req` and lasts 1 cycle.
- IRQ_EN=16'h0001; drive `pins_in[0]` 0→1 before edge K -> INPUT bit 0 reads 1 from K+1, IRQ_STAT=16'h0001 and `irq`=1 from K+2. Write IRQ_STAT=16'h0001 -> `irq`=0.
- W1C of bit 3 in the same cycle as rise[3] -> IRQ_STAT bit 3 remains 1.
- Read address 7 and write address 2 with 16'hFFFF -> `rdata`=0, INPUT unchanged, both accesses acked.
- Assert `reset` one cycle after `req` on a DIR write of 16'hFFFF -> no `ack`, `dir_out` stays 0 after release.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO bank controller: register map,
// access FSM states and the post-reset edge-detector priming length.
package gpio_ctrl_pkg;

    localparam int ADDR_DATA     = 0;
    localparam int ADDR_DIR      = 1;
    localparam int ADDR_INPUT    = 2;
    localparam int ADDR_IRQ_EN   = 3;
    localparam int ADDR_IRQ_STAT = 4;
    localparam int ADDR_SET      = 5;
    localparam int ADDR_CLR      = 6;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Cycles after reset release during which rise is suppressed.
    localparam logic [1:0] PRIME_COUNT = 2'd3;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for the asynchronous pin readback, plus a previous-
// sample flop for rising-edge detection, gated until the pipeline has primed.
module gpio_sync_edge
    import gpio_ctrl_pkg::*;
#(
    parameter int NPINS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPINS-1:0] pins_in,
    output logic [NPINS-1:0] sync_out,
    output logic [NPINS-1:0] rise
);

    logic [NPINS-1:0] sync1;
    logic [NPINS-1:0] sync2;
    logic [NPINS-1:0] prev;
    logic [1:0]       prime_cnt;
    logic             primed;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            sync1 <= pins_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (prime_cnt != PRIME_COUNT) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    // Pins already high at reset look like edges until prev catches up.
    assign primed   = (prime_cnt == PRIME_COUNT);
    assign sync_out = sync2;
    assign rise     = primed ? (sync2 & ~prev) : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO bank controller: single-outstanding req/ack access FSM,
// data/direction/interrupt registers and a maskable rising-edge interrupt.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int NPINS = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [NPINS-1:0] wdata,
    output logic             ack,
    output logic [NPINS-1:0] rdata,
    output logic [NPINS-1:0] data_out,
    output logic [NPINS-1:0] dir_out,
    input  logic [NPINS-1:0] pins_in,
    output logic             irq
);

    state_t           state;
    state_t           next_state;
    logic             access;
    logic             wr;
    logic             rd;
    logic [NPINS-1:0] data_r;
    logic [NPINS-1:0] dir_r;
    logic [NPINS-1:0] irq_en_r;
    logic [NPINS-1:0] irq_stat_r;
    logic [NPINS-1:0] rdata_r;
    logic [NPINS-1:0] read_value;
    logic [NPINS-1:0] w1c_mask;
    logic [NPINS-1:0] pins_sync;
    logic [NPINS-1:0] rise;

    gpio_sync_edge #(
        .NPINS(NPINS)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .pins_in (pins_in),
        .sync_out(pins_sync),
        .rise    (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        ack        = 1'b0;
        case (state)
            IDLE: if (req) next_state = ACK;
            ACK: begin
                ack        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign access = (state == IDLE) && req;
    assign wr     = access && we;
    assign rd     = access && !we;

    // Write-only and reserved addresses read back as zero.
    always_comb begin
        read_value = '0;
        case (addr)
            AW'(ADDR_DATA):     read_value = data_r;
            AW'(ADDR_DIR):      read_value = dir_r;
            AW'(ADDR_INPUT):    read_value = pins_sync;
            AW'(ADDR_IRQ_EN):   read_value = irq_en_r;
            AW'(ADDR_IRQ_STAT): read_value = irq_stat_r;
            default:            read_value = '0;
        endcase
    end

    assign w1c_mask = (wr && (addr == AW'(ADDR_IRQ_STAT))) ? wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r   <= '0;
            dir_r    <= '0;
            irq_en_r <= '0;
            rdata_r  <= '0;
        end else begin
            if (rd) begin
                rdata_r <= read_value;
            end
            if (wr) begin
                case (addr)
                    AW'(ADDR_DATA):   data_r   <= wdata;
                    AW'(ADDR_DIR):    dir_r    <= wdata;
                    AW'(ADDR_IRQ_EN): irq_en_r <= wdata;
                    AW'(ADDR_SET):    data_r   <= data_r | wdata;
                    AW'(ADDR_CLR):    data_r   <= data_r & ~wdata;
                    default: ;
                endcase
            end
        end
    end

    // A rise in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_stat_r <= '0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~w1c_mask) | rise;
        end
    end

    assign rdata    = rdata_r;
    assign data_out = data_r;
    assign dir_out  = dir_r;
    assign irq      = |(irq_stat_r & irq_en_r);

endmodule
